// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared types and constants for the read-data return path
package axi_rd_pkg;

    localparam int NUM_S  = 6;
    localparam int NUM_M  = 3;
    localparam int IDS_W  = 8;
    localparam int IDM_W  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [IDM_W-1:0]  id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // Cyclic successor over the slave indices 0..NUM_S-1.
    function automatic logic [2:0] wrap_inc(input logic [2:0] x);
        return (x == 3'(NUM_S - 1)) ? 3'd0 : x + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter6.sv
// rtl/rr_arbiter6.sv - six-way round-robin arbiter with registered last-winner pointer
module rr_arbiter6
    import axi_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    input  logic       update,
    input  logic [2:0] upd_idx,
    output logic [5:0] gnt,
    output logic [2:0] gnt_idx
);

    logic [2:0] last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 3'(NUM_S - 1);
        end else if (update) begin
            last <= upd_idx;
        end
    end

    // Scan starting just after the previous winner; first requester wins.
    always_comb begin
        logic [2:0] idx;
        logic       found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = last;
        for (int i = 0; i < NUM_S; i++) begin
            idx = wrap_inc(idx);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/read_data_router.sv
// rtl/read_data_router.sv - AXI R-channel router, six slaves to three masters, burst-locked RR grant
// Optional registered output slice per master when RD_PIPE_EN is defined.
module read_data_router #(
    parameter int DATA_W = 32,
    parameter int IDM_W  = 4,
    parameter int IDS_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  RID_S0,
    input  logic [IDS_W-1:0]  RID_S1,
    input  logic [IDS_W-1:0]  RID_S2,
    input  logic [IDS_W-1:0]  RID_S3,
    input  logic [IDS_W-1:0]  RID_S4,
    input  logic [IDS_W-1:0]  RID_S5,
    input  logic [DATA_W-1:0] RDATA_S0,
    input  logic [DATA_W-1:0] RDATA_S1,
    input  logic [DATA_W-1:0] RDATA_S2,
    input  logic [DATA_W-1:0] RDATA_S3,
    input  logic [DATA_W-1:0] RDATA_S4,
    input  logic [DATA_W-1:0] RDATA_S5,
    input  logic [1:0]        RRESP_S0,
    input  logic [1:0]        RRESP_S1,
    input  logic [1:0]        RRESP_S2,
    input  logic [1:0]        RRESP_S3,
    input  logic [1:0]        RRESP_S4,
    input  logic [1:0]        RRESP_S5,
    input  logic              RLAST_S0,
    input  logic              RLAST_S1,
    input  logic              RLAST_S2,
    input  logic              RLAST_S3,
    input  logic              RLAST_S4,
    input  logic              RLAST_S5,
    input  logic              RVALID_S0,
    input  logic              RVALID_S1,
    input  logic              RVALID_S2,
    input  logic              RVALID_S3,
    input  logic              RVALID_S4,
    input  logic              RVALID_S5,
    output logic              RREADY_S0,
    output logic              RREADY_S1,
    output logic              RREADY_S2,
    output logic              RREADY_S3,
    output logic              RREADY_S4,
    output logic              RREADY_S5,
    output logic [IDM_W-1:0]  RID_M0,
    output logic [IDM_W-1:0]  RID_M1,
    output logic [IDM_W-1:0]  RID_M2,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [DATA_W-1:0] RDATA_M2,
    output logic [1:0]        RRESP_M0,
    output logic [1:0]        RRESP_M1,
    output logic [1:0]        RRESP_M2,
    output logic              RLAST_M0,
    output logic              RLAST_M1,
    output logic              RLAST_M2,
    output logic              RVALID_M0,
    output logic              RVALID_M1,
    output logic              RVALID_M2,
    input  logic              RREADY_M0,
    input  logic              RREADY_M1,
    input  logic              RREADY_M2,
    output logic              rd_decerr
);

    import axi_rd_pkg::*;

    localparam int MIDX_W = IDS_W - IDM_W;

    logic [IDS_W-1:0]  rid_s   [NUM_S];
    logic [DATA_W-1:0] rdata_s [NUM_S];
    logic [1:0]        rresp_s [NUM_S];
    logic [5:0]        rlast_s, rvalid_s, rready_s;
    logic [2:0]        rready_m, rvalid_m;
    r_beat_t           beat_m  [NUM_M];

    assign rid_s   = '{RID_S0, RID_S1, RID_S2, RID_S3, RID_S4, RID_S5};
    assign rdata_s = '{RDATA_S0, RDATA_S1, RDATA_S2, RDATA_S3, RDATA_S4, RDATA_S5};
    assign rresp_s = '{RRESP_S0, RRESP_S1, RRESP_S2, RRESP_S3, RRESP_S4, RRESP_S5};
    assign rlast_s  = {RLAST_S5, RLAST_S4, RLAST_S3, RLAST_S2, RLAST_S1, RLAST_S0};
    assign rvalid_s = {RVALID_S5, RVALID_S4, RVALID_S3, RVALID_S2, RVALID_S1, RVALID_S0};
    assign rready_m = {RREADY_M2, RREADY_M1, RREADY_M0};

    assign {RREADY_S5, RREADY_S4, RREADY_S3, RREADY_S2, RREADY_S1, RREADY_S0} = rready_s;
    assign {RVALID_M2, RVALID_M1, RVALID_M0} = rvalid_m;
    assign {RID_M0, RDATA_M0, RRESP_M0, RLAST_M0} = beat_m[0];
    assign {RID_M1, RDATA_M1, RRESP_M1, RLAST_M1} = beat_m[1];
    assign {RID_M2, RDATA_M2, RRESP_M2, RLAST_M2} = beat_m[2];

    rd_state_e         state, state_nx;
    logic [2:0]        gnt_q;
    logic [MIDX_W-1:0] mst_q;
    logic [5:0]        arb_gnt;
    logic [2:0]        arb_idx;
    logic              arb_ld, arb_upd;
    logic [2:0]        mst_hot;
    logic              sel_valid, sel_ready;
    r_beat_t           sel_beat;

    rr_arbiter6 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rvalid_s),
        .update  (arb_upd),
        .upd_idx (gnt_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Master index is captured once at arbitration and held for the whole burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= '0;
            mst_q <= '0;
        end else begin
            state <= state_nx;
            if (arb_ld) begin
                gnt_q <= arb_idx;
                mst_q <= rid_s[arb_idx][IDS_W-1:IDM_W];
            end
        end
    end

    always_comb begin
        mst_hot = '0;
        for (int k = 0; k < NUM_M; k++) begin
            mst_hot[k] = (state == BURST) && (mst_q == MIDX_W'(k));
        end
    end

    assign sel_valid = rvalid_s[gnt_q];
    assign sel_beat  = '{id:   rid_s[gnt_q][IDM_W-1:0],
                         data: rdata_s[gnt_q],
                         resp: rresp_s[gnt_q],
                         last: rlast_s[gnt_q]};

`ifdef RD_PIPE_EN
    logic [2:0] full_q;
    r_beat_t    slice_q [NUM_M];

    // Slice accepts a new beat whenever it is empty or draining this cycle.
    assign sel_ready = (mst_hot == '0) ? 1'b1 : |(mst_hot & (~full_q | rready_m));

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_M; k++) begin
            if (rst) begin
                full_q[k]  <= 1'b0;
                slice_q[k] <= '0;
            end else if (mst_hot[k] && sel_valid && sel_ready) begin
                full_q[k]  <= 1'b1;
                slice_q[k] <= sel_beat;
            end else if (rready_m[k]) begin
                full_q[k]  <= 1'b0;
            end
        end
    end

    assign rvalid_m = full_q;
    assign beat_m   = slice_q;
`else
    assign sel_ready = (mst_hot == '0) ? 1'b1 : |(mst_hot & rready_m);

    always_comb begin
        rvalid_m = '0;
        for (int k = 0; k < NUM_M; k++) begin
            beat_m[k] = '0;
            if (mst_hot[k]) begin
                rvalid_m[k] = sel_valid;
                beat_m[k]   = sel_beat;
            end
        end
    end
`endif

    always_comb begin
        state_nx  = state;
        arb_ld    = 1'b0;
        arb_upd   = 1'b0;
        rready_s  = '0;
        rd_decerr = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_gnt) begin
                    arb_ld   = 1'b1;
                    state_nx = BURST;
                end
            end
            BURST: begin
                rready_s[gnt_q] = sel_ready;
                if (sel_valid && sel_ready && sel_beat.last) begin
                    state_nx  = IDLE;
                    arb_upd   = 1'b1;
                    rd_decerr = (mst_hot == '0);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_read_data_router.sv
// tb/tb_read_data_router.sv - directed self-checking bench for read_data_router (default build)
module tb_read_data_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rid_s   [6];
    logic [31:0] rdata_s [6];
    logic [1:0]  rresp_s [6];
    logic [5:0]  rlast_s, rvalid_s, rready_s;
    logic [3:0]  rid_m   [3];
    logic [31:0] rdata_m [3];
    logic [1:0]  rresp_m [3];
    logic [2:0]  rlast_m, rvalid_m, rready_m;
    logic        rd_decerr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    read_data_router dut (
        .clk(clk), .rst(rst),
        .RID_S0(rid_s[0]), .RID_S1(rid_s[1]), .RID_S2(rid_s[2]),
        .RID_S3(rid_s[3]), .RID_S4(rid_s[4]), .RID_S5(rid_s[5]),
        .RDATA_S0(rdata_s[0]), .RDATA_S1(rdata_s[1]), .RDATA_S2(rdata_s[2]),
        .RDATA_S3(rdata_s[3]), .RDATA_S4(rdata_s[4]), .RDATA_S5(rdata_s[5]),
        .RRESP_S0(rresp_s[0]), .RRESP_S1(rresp_s[1]), .RRESP_S2(rresp_s[2]),
        .RRESP_S3(rresp_s[3]), .RRESP_S4(rresp_s[4]), .RRESP_S5(rresp_s[5]),
        .RLAST_S0(rlast_s[0]), .RLAST_S1(rlast_s[1]), .RLAST_S2(rlast_s[2]),
        .RLAST_S3(rlast_s[3]), .RLAST_S4(rlast_s[4]), .RLAST_S5(rlast_s[5]),
        .RVALID_S0(rvalid_s[0]), .RVALID_S1(rvalid_s[1]), .RVALID_S2(rvalid_s[2]),
        .RVALID_S3(rvalid_s[3]), .RVALID_S4(rvalid_s[4]), .RVALID_S5(rvalid_s[5]),
        .RREADY_S0(rready_s[0]), .RREADY_S1(rready_s[1]), .RREADY_S2(rready_s[2]),
        .RREADY_S3(rready_s[3]), .RREADY_S4(rready_s[4]), .RREADY_S5(rready_s[5]),
        .RID_M0(rid_m[0]), .RID_M1(rid_m[1]), .RID_M2(rid_m[2]),
        .RDATA_M0(rdata_m[0]), .RDATA_M1(rdata_m[1]), .RDATA_M2(rdata_m[2]),
        .RRESP_M0(rresp_m[0]), .RRESP_M1(rresp_m[1]), .RRESP_M2(rresp_m[2]),
        .RLAST_M0(rlast_m[0]), .RLAST_M1(rlast_m[1]), .RLAST_M2(rlast_m[2]),
        .RVALID_M0(rvalid_m[0]), .RVALID_M1(rvalid_m[1]), .RVALID_M2(rvalid_m[2]),
        .RREADY_M0(rready_m[0]), .RREADY_M1(rready_m[1]), .RREADY_M2(rready_m[2]),
        .rd_decerr(rd_decerr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] bd [4];
    logic [31:0] got [$];
    int          b;
    logic        pat [6];
    logic [2:0]  rr_exp [4];

    initial begin
        rst      = 1'b1;
        rlast_s  = '0;
        rvalid_s = '0;
        rready_m = '0;
        for (int i = 0; i < 6; i++) begin
            rid_s[i]   = '0;
            rdata_s[i] = '0;
            rresp_s[i] = '0;
        end
        tick();
        tick();
        settle();
        check("reset_rvalid_m", 64'(rvalid_m), 64'h0);
        check("reset_rready_s", 64'(rready_s), 64'h0);
        check("reset_decerr", 64'(rd_decerr), 64'h0);
        check("reset_rdata_m1", 64'(rdata_m[1]), 64'h0);
        rst = 1'b0;
        tick();

        // Single-beat read S2 -> M1
        rvalid_s[2] = 1'b1;
        rid_s[2]    = 8'h13;
        rdata_s[2]  = 32'hDEADBEEF;
        rresp_s[2]  = 2'b01;
        rlast_s[2]  = 1'b1;
        rready_m[1] = 1'b1;
        settle();
        check("single_idle_no_valid", 64'(rvalid_m), 64'h0);
        check("single_idle_no_ready", 64'(rready_s), 64'h0);
        tick();
        check("single_rvalid_m", 64'(rvalid_m), 64'b010);
        check("single_rid_m1", 64'(rid_m[1]), 64'h3);
        check("single_rdata_m1", 64'(rdata_m[1]), 64'hDEADBEEF);
        check("single_rresp_m1", 64'(rresp_m[1]), 64'h1);
        check("single_rlast_m1", 64'(rlast_m[1]), 64'h1);
        check("single_rready_s", 64'(rready_s), 64'b000100);
        check("single_other_m0", 64'(rdata_m[0]), 64'h0);
        tick();
        rvalid_s[2] = 1'b0;
        rlast_s[2]  = 1'b0;
        rready_m[1] = 1'b0;
        settle();
        check("single_back_idle", 64'(rvalid_m), 64'h0);

        // Four-beat burst S5 -> M0 with two stall cycles; index change mid-burst ignored
        bd  = '{32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        b   = 0;
        rvalid_s[5] = 1'b1;
        rid_s[5]    = 8'h05;
        rdata_s[5]  = bd[0];
        rlast_s[5]  = 1'b0;
        rready_m[0] = 1'b1;
        settle();
        check("burst_idle_latency", 64'(rvalid_m), 64'h0);
        tick();
        for (int c = 0; c < 6; c++) begin
            rready_m[0] = pat[c];
            rid_s[5]    = (c == 0) ? 8'h05 : 8'h25;
            rdata_s[5]  = bd[b];
            rlast_s[5]  = (b == 3);
            settle();
            check("burst_rvalid_m", 64'(rvalid_m), 64'b001);
            check("burst_rid_m0", 64'(rid_m[0]), 64'h5);
            check("burst_rdata_m0", 64'(rdata_m[0]), 64'(bd[b]));
            check("burst_rready_s", 64'(rready_s), pat[c] ? 64'b100000 : 64'h0);
            if (rvalid_m[0] && rready_m[0]) begin
                got.push_back(rdata_m[0]);
                b++;
            end
            tick();
        end
        check("burst_beat_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check("burst_beat_order", 64'(got[i]), 64'(bd[i]));
        end
        rvalid_s[5] = 1'b0;
        rlast_s[5]  = 1'b0;
        rready_m[0] = 1'b0;
        settle();
        check("burst_back_idle", 64'(rvalid_m), 64'h0);

        // Round robin after reset: S0, S3, S5 keep requesting single beats to M0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_exp = '{3'd0, 3'd3, 3'd5, 3'd0};
        foreach (rr_exp[i]) begin
            rid_s[i] = rid_s[i];
        end
        rid_s[0] = 8'h00; rid_s[3] = 8'h03; rid_s[5] = 8'h05;
        rdata_s[0] = 32'h0000_0C00; rdata_s[3] = 32'h0000_0C03; rdata_s[5] = 32'h0000_0C05;
        rlast_s  = 6'b101001;
        rvalid_s = 6'b101001;
        rready_m[0] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("rr_grant", 64'(rready_s), 64'(6'b1 << rr_exp[g]));
            check("rr_rdata_m0", 64'(rdata_m[0]), 64'(32'h0000_0C00 | 32'(rr_exp[g])));
            tick();
            check("rr_gap_idle", 64'(rvalid_m), 64'h0);
        end
        rvalid_s = '0;
        rlast_s  = '0;
        rready_m = '0;

        // Invalid master index 7 from S1, two beats sunk
        rvalid_s[1] = 1'b1;
        rid_s[1]    = 8'h72;
        rdata_s[1]  = 32'h1234_5678;
        tick();
        check("decerr_no_valid0", 64'(rvalid_m), 64'h0);
        check("decerr_sink_ready0", 64'(rready_s), 64'b000010);
        check("decerr_not_yet", 64'(rd_decerr), 64'h0);
        tick();
        rlast_s[1] = 1'b1;
        settle();
        check("decerr_no_valid1", 64'(rvalid_m), 64'h0);
        check("decerr_sink_ready1", 64'(rready_s), 64'b000010);
        check("decerr_pulse", 64'(rd_decerr), 64'h1);
        tick();
        rvalid_s[1] = 1'b0;
        rlast_s[1]  = 1'b0;
        settle();
        check("decerr_cleared", 64'(rd_decerr), 64'h0);

        // Reset on beat 2 of a 4-beat burst S4 -> M2, then S0 vs S4 re-arbitration
        rvalid_s[4] = 1'b1;
        rid_s[4]    = 8'h21;
        rdata_s[4]  = 32'hB000_0000;
        rready_m[2] = 1'b1;
        tick();
        check("rst_burst_beat0", 64'(rvalid_m), 64'b100);
        check("rst_burst_rid", 64'(rid_m[2]), 64'h1);
        rdata_s[4] = 32'hB000_0001;
        tick();
        check("rst_burst_beat1", 64'(rready_s), 64'b010000);
        rst = 1'b1;
        tick();
        check("rst_mid_rvalid_m", 64'(rvalid_m), 64'h0);
        check("rst_mid_rready_s", 64'(rready_s), 64'h0);
        rst = 1'b0;
        rvalid_s[0] = 1'b1;
        rid_s[0]    = 8'h00;
        rdata_s[0]  = 32'hC0C0_C0C0;
        rlast_s[0]  = 1'b1;
        rready_m[0] = 1'b1;
        tick();
        check("rst_rearb_s0_wins", 64'(rready_s), 64'b000001);
        check("rst_rearb_rvalid", 64'(rvalid_m), 64'b001);
        check("rst_rearb_rdata", 64'(rdata_m[0]), 64'hC0C0_C0C0);
        tick();
        rvalid_s = '0;
        rlast_s  = '0;
        rready_m = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_data_router.md
Name: read_data_router

Overview:
- AXI read-data (R) channel return path of the interconnect: routes read-data beats from the 6 slaves (S0 ROM, S1 IM, S2 DM, S3 DMA, S4 WDT, S5 DRAM) back to the 3 masters (M0..M2).
- Routing is by the master index carried in the upper nibble of the slave-side ID.
- A round-robin arbiter picks among slaves with pending RVALID. The grant is locked for a whole burst, until the RLAST handshake.
- Sits beside the read-address path in the AXI interconnect.

Parameters:
- DATA_W, 32, RDATA width.
- IDM_W, 4, master-side ID width.
- IDS_W, 8, slave-side ID width; RID_S[7:4] = master index, RID_S[3:0] = master ID.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset; synchronous, active-high.
- RID_S0..RID_S5  input  IDS_W each  slave read ID.
- RDATA_S0..RDATA_S5  input  DATA_W each  slave read data.
- RRESP_S0..RRESP_S5  input  2 each  slave response.
- RLAST_S0..RLAST_S5  input  1 each  last beat of burst.
- RVALID_S0..RVALID_S5  input  1 each  slave beat valid.
- RREADY_S0..RREADY_S5  output  1 each  ready back to slave.
- RID_M0..RID_M2  output  IDM_W each  ID to master (RID_S[3:0]).
- RDATA_M0..RDATA_M2  output  DATA_W each  data to master.
- RRESP_M0..RRESP_M2  output  2 each  response to master.
- RLAST_M0..RLAST_M2  output  1 each  last beat.
- RVALID_M0..RVALID_M2  output  1 each  beat valid to master.
- RREADY_M0..RREADY_M2  input  1 each  master ready.
- rd_decerr  output  1  one-cycle pulse when a burst to an invalid master index (>=3) is sunk.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, no grant, round-robin pointer last=S5 (so S0 has top priority).
  - All RVALID_Mx=0, RREADY_Sx=0, rd_decerr=0, all data/ID outputs 0.
- State machine IDLE -> BURST -> IDLE:
  - IDLE:
    - If any RVALID_Sx=1, the winner is the first requesting slave after `last` in cyclic order S0..S5.
    - Register the winner as grant, latch its master index (RID_S[7:4]), go to BURST.
    - No beat transfers in IDLE; arbitration latency is 1 cycle.
  - BURST, valid index m<3:
    - RVALID_Mm = RVALID_Sg; RREADY_Sg = RREADY_Mm.
    - RID_Mm = RID_Sg[3:0]; RDATA/RRESP/RLAST pass through combinationally.
    - All other RVALID_M and RREADY_S are 0; non-selected master outputs are 0.
  - BURST, index m>=3:
    - RREADY_Sg=1, all RVALID_M=0 (beats are sunk).
    - rd_decerr pulses in the cycle of the RLAST handshake.
  - Exit from BURST: on RVALID_Sg & ready & RLAST_Sg, go to IDLE next cycle and set last=g.
- Master index is sampled once per burst. Index changes mid-burst are ignored.
- Beats without RLAST keep the grant. A single-beat burst (RLAST on the first beat) returns to IDLE after 1 beat.
- Throughput: one beat per cycle within a burst; 1 idle cycle between bursts.
- Simultaneous requests: strictly round-robin. After S0 finishes, with S0 and S3 both requesting, S3 wins.
- Master back-pressure: RREADY_Mm=0 holds the beat; slave outputs must remain stable (AXI rule); the router adds no state.
- Reset mid-burst: grant is dropped immediately at the clock edge; outputs return to reset values.

Optional Feature:
- Macro: RD_PIPE_EN.
- Defined:
  - A one-entry registered output slice per master path.
  - RVALID_M/RDATA_M/RID_M/RRESP_M/RLAST_M come from flops.
  - RREADY_Sg = ~slice_full | RREADY_Mm.
  - +1 cycle latency, full throughput preserved.
  - The RLAST exit condition is evaluated on the slave-side handshake into the slice.
  - Slice flops clear on rst.
- Undefined: combinational pass-through as described above.

Decomposition:
- Package axi_rd_pkg:
  - Constants NUM_S=6, NUM_M=3, IDS_W, IDM_W.
  - typedef r_beat_t {id, data, resp, last}.
  - enum rd_state_e {IDLE, BURST}.
- Sub-module rr_arbiter6: 6-bit request, registered `last` pointer, one-hot grant, update strobe.

Test Plan:
- Single-beat read:
  - Stimulus: RVALID_S2=1, RID_S2=8'h13, RDATA_S2=32'hDEADBEEF, RLAST=1, RREADY_M1=1.
  - Response: cycle after detect, RVALID_M1=1, RID_M1=4'h3, RDATA_M1=32'hDEADBEEF; RREADY_S2=1 that cycle; back to IDLE.
- 4-beat burst with back-pressure:
  - Stimulus: S5 sends ID 8'h05 to M0; RREADY_M0 low for 2 cycles mid-burst.
  - Response: 4 beats in order, none lost or duplicated; grant held until RLAST handshake.
- Round-robin fairness:
  - Stimulus: after reset, S0, S3, S5 all RVALID with single-beat bursts.
  - Response: grant order S0, S3, S5, then S0 again if still requesting.
- Invalid master index:
  - Stimulus: RID_S1=8'h72, 2-beat burst.
  - Response: no RVALID_M asserted, RREADY_S1=1 both beats, rd_decerr=1 for exactly the RLAST cycle.
- Reset mid-burst:
  - Stimulus: rst=1 on beat 2 of 4.
  - Response: next cycle all RVALID_M=0, RREADY_S=0; the next request re-arbitrates starting from S0.
- With RD_PIPE_EN defined:
  - Stimulus: same as the single-beat test.
  - Response: RVALID_M1 one cycle later; back-to-back beats show no bubbles.
